// File: rtl/reg_file_pkg.sv
// Shared types and sizes for the register file.
// Package rf_pkg: widths, address/data typedefs, sequencer state enum.
package rf_pkg;

    localparam int RF_DATA_W = 8;
    localparam int RF_ADDR_W = 5;

    typedef logic [RF_DATA_W-1:0] rf_data_t;
    typedef logic [RF_ADDR_W-1:0] rf_addr_t;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_t;

endpackage

// File: rtl/reg_file_if.sv
// Register file access bundle between the datapath and the array.
// Signals: DIN, ADRX, ADRY, RF_WR (to array); DX_OUT, DY_OUT, READY (back).
interface reg_file_if #(
    parameter int DATA_W = rf_pkg::RF_DATA_W,
    parameter int ADDR_W = rf_pkg::RF_ADDR_W
);

    logic [DATA_W-1:0] DIN;
    logic [ADDR_W-1:0] ADRX;
    logic [ADDR_W-1:0] ADRY;
    logic              RF_WR;
    logic [DATA_W-1:0] DX_OUT;
    logic [DATA_W-1:0] DY_OUT;
    logic              READY;

    modport master (
        output DIN, ADRX, ADRY, RF_WR,
        input  DX_OUT, DY_OUT, READY
    );

    modport slave (
        input  DIN, ADRX, ADRY, RF_WR,
        output DX_OUT, DY_OUT, READY
    );

endinterface

// File: rtl/reg_file_clear_seq.sv
// Post-reset clear sequencer: walks every address writing zero, then runs.
// Ports: clk_i, rst_i (sync, active-high), clr_we_o, clr_addr_o, ready_o.
module rf_clear_seq
    import rf_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic              clr_we_o,
    output logic [ADDR_W-1:0] clr_addr_o,
    output logic              ready_o
);

    localparam int          DEPTH = 2 ** ADDR_W;
    localparam [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

    rf_state_t         state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              ready_q, ready_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    // Exit is decoded from the last address, not from counter wrap.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ready_d  = ready_q;
        clr_we_o = 1'b0;
        unique case (state_q)
            CLEAR: begin
                clr_we_o = 1'b1;
                cnt_d    = cnt_q + ADDR_W'(1);
                if (cnt_q == LAST) begin
                    state_d = RUN;
                    ready_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                clr_we_o = 1'b0;
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
                ready_d = 1'b0;
            end
        endcase
    end

    assign clr_addr_o = cnt_q;
    assign ready_o    = ready_q;

endmodule

// File: rtl/reg_file.sv
// Dual-read, single-write register file with post-reset clear sequencer.
// Ports: CLK, RST (sync, active-high), rf (slave: DIN/ADRX/ADRY/RF_WR ->
// DX_OUT/DY_OUT/READY). Optional REG_FILE_BYPASS_EN: write-first forwarding.
module reg_file
    import rf_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic       CLK,
    input  logic       RST,
    reg_file_if.slave  rf
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              ready;

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;

    rf_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_seq (
        .clk_i      (CLK),
        .rst_i      (RST),
        .clr_we_o   (clr_we),
        .clr_addr_o (clr_addr),
        .ready_o    (ready)
    );

    // Clear port owns the array until READY; RF_WR is dropped, not queued.
    always_comb begin
        we    = 1'b0;
        waddr = rf.ADRX;
        wdata = rf.DIN;
        if (clr_we) begin
            we    = 1'b1;
            waddr = clr_addr;
            wdata = '0;
        end else if (ready && rf.RF_WR && !RST) begin
            we = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_comb begin
        rf.DX_OUT = '0;
        rf.DY_OUT = '0;
        if (ready) begin
            rf.DX_OUT = mem_q[rf.ADRX];
            rf.DY_OUT = mem_q[rf.ADRY];
`ifdef REG_FILE_BYPASS_EN
            if (rf.RF_WR) begin
                rf.DX_OUT = rf.DIN;
                if (rf.ADRY == rf.ADRX) begin
                    rf.DY_OUT = rf.DIN;
                end
            end
`endif
        end
    end

    assign rf.READY = ready;

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: clear timing, ignored writes, read/write,
// same-cycle read/write, reset mid-clear and reset from run.
module tb_reg_file;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   n;

    always #5 CLK = ~CLK;

    reg_file_if #(.DATA_W(8), .ADDR_W(5)) rf ();

    reg_file dut (
        .CLK (CLK),
        .RST (RST),
        .rf  (rf.slave)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic reset_seq(input int hold);
        @(negedge CLK);
        RST = 1'b1;
        repeat (hold) @(negedge CLK);
        RST = 1'b0;
    endtask

    // Counts edges until READY; optionally pokes a write at edge wr_at.
    task automatic wait_ready(input int wr_at, output int cnt);
        cnt = 0;
        while (!rf.READY && cnt < 100) begin
            @(posedge CLK);
            #1;
            cnt++;
            if (cnt == wr_at) begin
                rf.ADRX  = 5'd5;
                rf.ADRY  = 5'd5;
                rf.DIN   = 8'hAA;
                rf.RF_WR = 1'b1;
                #1;
                check("clr_dx_forced0", rf.DX_OUT, 8'h00);
                check("clr_dy_forced0", rf.DY_OUT, 8'h00);
            end else if (cnt == wr_at + 1) begin
                rf.RF_WR = 1'b0;
            end
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        @(negedge CLK);
        rf.ADRX  = a;
        rf.DIN   = d;
        rf.RF_WR = 1'b1;
        @(posedge CLK);
        #1;
        rf.RF_WR = 1'b0;
    endtask

    task automatic read_all(input string tag, input logic [7:0] exp);
        for (int i = 0; i < 32; i++) begin
            @(negedge CLK);
            rf.ADRX = 5'(i);
            rf.ADRY = 5'(31 - i);
            #1;
            check({tag, "_x"}, rf.DX_OUT, exp);
            check({tag, "_y"}, rf.DY_OUT, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rf.DIN   = '0;
        rf.ADRX  = '0;
        rf.ADRY  = '0;
        rf.RF_WR = 1'b0;

        // 1 + 2: reset, clear timing, write ignored during clear
        reset_seq(2);
        #1;
        check("rst_ready", rf.READY, 1'b0);
        check("rst_dx", rf.DX_OUT, 8'h00);
        check("rst_dy", rf.DY_OUT, 8'h00);
        wait_ready(10, n);
        check("clear_cycles", n, 32);
        check("ready_high", rf.READY, 1'b1);
        read_all("clr0", 8'h00);
        @(negedge CLK);
        rf.ADRX = 5'd5;
        #1;
        check("clr_wr_ignored", rf.DX_OUT, 8'h00);

        // 3: write then read
        wr(5'd7, 8'h3C);
        wr(5'd31, 8'hC3);
        @(negedge CLK);
        rf.ADRX = 5'd7;
        rf.ADRY = 5'd31;
        #1;
        check("rd_x7", rf.DX_OUT, 8'h3C);
        check("rd_y31", rf.DY_OUT, 8'hC3);
        rf.ADRY = 5'd7;
        #1;
        check("same_x", rf.DX_OUT, 8'h3C);
        check("same_y", rf.DY_OUT, 8'h3C);

        // 4: same-cycle read/write
        wr(5'd3, 8'h11);
        @(negedge CLK);
        rf.ADRX  = 5'd3;
        rf.ADRY  = 5'd3;
        rf.DIN   = 8'h22;
        rf.RF_WR = 1'b1;
        #1;
`ifdef REG_FILE_BYPASS_EN
        check("rw_same_y", rf.DY_OUT, 8'h22);
        check("rw_same_x", rf.DX_OUT, 8'h22);
`else
        check("rw_same_y", rf.DY_OUT, 8'h11);
        check("rw_same_x", rf.DX_OUT, 8'h11);
`endif
        @(posedge CLK);
        #1;
        rf.RF_WR = 1'b0;
        #1;
        check("rw_next_y", rf.DY_OUT, 8'h22);
        rf.ADRY = 5'd7;
        #1;
        check("rw_other_y", rf.DY_OUT, 8'h3C);

        // 5: reset mid-clear
        reset_seq(2);
        repeat (20) @(posedge CLK);
        #1;
        check("mid_ready", rf.READY, 1'b0);
        reset_seq(1);
        wait_ready(0, n);
        check("mid_cycles", n, 32);
        rf.ADRX = 5'd7;
        rf.ADRY = 5'd3;
        #1;
        check("mid_x7", rf.DX_OUT, 8'h00);
        check("mid_y3", rf.DY_OUT, 8'h00);

        // 6: reset from run
        for (int i = 0; i < 32; i++) wr(5'(i), 8'hFF);
        read_all("ff", 8'hFF);
        reset_seq(1);
        #1;
        check("run_rst_ready", rf.READY, 1'b0);
        check("run_rst_dx", rf.DX_OUT, 8'h00);
        wait_ready(0, n);
        check("run_rst_cycles", n, 32);
        read_all("clr1", 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
